// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Buffers ALU commands in a small circular FIFO, issues them one at a time
// to an external combinational ALU through registered operand ports, and
// returns each captured ALU result through a valid/ready response channel.
//
// Ports
//   clk, rst_n               : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake (cmd_a, cmd_b, cmd_opsel)
//   alu_a/alu_b/alu_opsel    : registered operands driven to the ALU
//   alu_result               : combinational result returned by the ALU
//   rsp_valid/rsp_ready      : response handshake
//   rsp_result/rsp_opsel     : captured result and the opsel that made it
//   rsp_err                  : captured opsel is an undefined ALU op (11..15)
//   fifo_count               : entries currently held in the command FIFO
// ---------------------------------------------------------------------------
module alu_cmd_issuer #(
    parameter int WIDTH     = 8,
    parameter int MUL_WIDTH = 12,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [WIDTH-1:0]         cmd_a,
    input  logic [WIDTH-1:0]         cmd_b,
    input  logic [3:0]               cmd_opsel,
    output logic [WIDTH-1:0]         alu_a,
    output logic [WIDTH-1:0]         alu_b,
    output logic [3:0]               alu_opsel,
    input  logic [MUL_WIDTH-1:0]     alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [MUL_WIDTH-1:0]     rsp_result,
    output logic [3:0]               rsp_opsel,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opsel values 11..15 have no defined ALU operation.
    function automatic logic is_undef_op(input logic [3:0] op);
        return (op >= 4'd11);
    endfunction

    logic [WIDTH-1:0] mem_a_r  [DEPTH];
    logic [WIDTH-1:0] mem_b_r  [DEPTH];
    logic [3:0]       mem_op_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             push_s;
    logic             pop_s;

    // Ready depends on occupancy only, so a pop in the same cycle never
    // lets a push into a full FIFO.
    assign cmd_ready  = (count_r != CNT_W'(DEPTH));
    assign push_s     = cmd_valid && cmd_ready;
    assign fifo_count = count_r;

    // Next-state and pop decision; pops happen only from IDLE or from an
    // accepted response, and only when the FIFO holds something.
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (count_r != {CNT_W{1'b0}}) begin
                    pop_s       = 1'b1;
                    state_nxt_s = EXEC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            EXEC: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    if (count_r != {CNT_W{1'b0}}) begin
                        pop_s       = 1'b1;
                        state_nxt_s = EXEC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FIFO storage, wrap-around pointers and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_r[i]  <= {WIDTH{1'b0}};
                mem_b_r[i]  <= {WIDTH{1'b0}};
                mem_op_r[i] <= 4'd0;
            end
        end else begin
            if (push_s) begin
                mem_a_r[wr_ptr_r]  <= cmd_a;
                mem_b_r[wr_ptr_r]  <= cmd_b;
                mem_op_r[wr_ptr_r] <= cmd_opsel;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            if (push_s && !pop_s) begin
                count_r <= count_r + CNT_W'(1);
            end else if (pop_s && !push_s) begin
                count_r <= count_r - CNT_W'(1);
            end
        end
    end

    // ALU operand registers: loaded only on a pop, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= {WIDTH{1'b0}};
            alu_b     <= {WIDTH{1'b0}};
            alu_opsel <= 4'd0;
        end else if (pop_s) begin
            alu_a     <= mem_a_r[rd_ptr_r];
            alu_b     <= mem_b_r[rd_ptr_r];
            alu_opsel <= mem_op_r[rd_ptr_r];
        end
    end

    // Response registers: capture at the end of EXEC, drop valid once the
    // consumer accepts; payload is held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= {MUL_WIDTH{1'b0}};
            rsp_opsel  <= 4'd0;
            rsp_err    <= 1'b0;
        end else if (state_r == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_opsel  <= alu_opsel;
            rsp_err    <= is_undef_op(alu_opsel);
        end else if ((state_r == RESP) && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

endmodule
